// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one memory command port between display read bursts and drawing writes.
// Optional feature macro VGA_ARB_UNDERRUN_EN enables the sticky underrun flag.
module vga_mem_arbiter #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 16
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    output logic              disp_done,
    input  logic              draw_valid,
    output logic              draw_ready,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_wdata,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [DATA_W-1:0] mem_cmd_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    input  logic              line_start,
    output logic              underrun
);
    localparam int CW = $clog2(BURST_LEN + 1);
    typedef enum logic [1:0] {IDLE, DISP_CMD, DISP_WAIT} state_t;
    state_t            state;
    logic [ADDR_W-1:0] rd_addr;
    logic [CW-1:0]     cmd_cnt;
    logic [CW-1:0]     rd_out;
    logic              rd_cmd;
    logic              draw_ok;
    logic              rd_hs;
    assign rd_cmd  = state == DISP_CMD;
    assign draw_ok = (state == IDLE && !disp_req) || state == DISP_WAIT;
    assign rd_hs   = rd_cmd && mem_cmd_ready;
    // Command mux and read-return gating; a pending display request blocks draws in IDLE
    always_comb begin
        mem_cmd_valid = rd_cmd || (draw_ok && draw_valid);
        mem_cmd_we    = !rd_cmd;
        mem_cmd_addr  = rd_cmd ? rd_addr : draw_addr;
        mem_cmd_wdata = draw_wdata;
        draw_ready    = draw_ok && mem_cmd_ready;
        disp_rvalid   = mem_rvalid && rd_out != '0;
        disp_rdata    = mem_rdata;
        disp_done     = disp_rvalid && state == DISP_WAIT && rd_out == CW'(1);
    end
    // Burst sequencer: accept, issue BURST_LEN reads, then wait for the last return
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rd_addr  <= '0;
            cmd_cnt  <= '0;
            disp_ack <= 1'b0;
        end else begin
            disp_ack <= 1'b0;
            case (state)
                IDLE: if (disp_req) begin
                    state    <= DISP_CMD;
                    rd_addr  <= disp_addr;
                    cmd_cnt  <= '0;
                    disp_ack <= 1'b1;
                end
                DISP_CMD: if (mem_cmd_ready) begin
                    rd_addr <= rd_addr + 1'b1;
                    cmd_cnt <= cmd_cnt + 1'b1;
                    if (cmd_cnt == CW'(BURST_LEN - 1)) state <= DISP_WAIT;
                end
                DISP_WAIT: if (disp_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    // Outstanding reads; simultaneous issue and return leave the count unchanged
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) rd_out <= '0;
        else if (rd_hs && !disp_rvalid) rd_out <= rd_out + 1'b1;
        else if (!rd_hs && disp_rvalid) rd_out <= rd_out - 1'b1;
    end
`ifdef VGA_ARB_UNDERRUN_EN
    // Sticky flag: a line started while a burst was still in flight
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) underrun <= 1'b0;
        else if (line_start && state != IDLE) underrun <= 1'b1;
    end
`else
    logic unused_line_start;
    assign unused_line_start = line_start;
    assign underrun = 1'b0;
`endif
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: table vectors for the draw path plus scoreboarded display bursts.
module tb_vga_mem_arbiter;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int BL = 16;
`ifdef VGA_ARB_UNDERRUN_EN
    localparam bit UEN = 1'b1;
`else
    localparam bit UEN = 1'b0;
`endif
    typedef struct {
        logic          dv;
        logic          rdy;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          ev;
        logic          er;
    } vec_t;
    logic          pixel_clk = 1'b0;
    logic          reset = 1'b1;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_ack, disp_rvalid, disp_done, draw_ready;
    logic          mem_cmd_valid, mem_cmd_we, underrun;
    logic [DW-1:0] disp_rdata, mem_cmd_wdata;
    logic [AW-1:0] mem_cmd_addr;
    logic          draw_valid = 1'b0;
    logic [AW-1:0] draw_addr = '0;
    logic [DW-1:0] draw_wdata = '0;
    logic          mem_cmd_ready;
    logic          tb_ready = 1'b1;
    logic          model_ready = 1'b1;
    logic          manual = 1'b1;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rvalid = 1'b0;
    logic          line_start = 1'b0;
    int vectors = 0, errors = 0, cyc = 0, latency = 3;
    bit rand_ready = 0, stray = 0, stalled = 0;
    int n_ack = 0, n_rd = 0, n_rv = 0, n_done = 0, wr_at_rd = -1, wr_at_rv = -1;
    logic [AW-1:0] stall_addr;
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];
    int            pend_due[$];
    logic [DW-1:0] pend_data[$];
    vec_t          vecs[5];

    assign mem_cmd_ready = manual ? tb_ready : model_ready;
    always #5 pixel_clk = ~pixel_clk;

    vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .pixel_clk(pixel_clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
        .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid), .disp_done(disp_done),
        .draw_valid(draw_valid), .draw_ready(draw_ready), .draw_addr(draw_addr), .draw_wdata(draw_wdata),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
        .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .line_start(line_start), .underrun(underrun)
    );

    function automatic logic [DW-1:0] mdata(logic [AW-1:0] a);
        return a[DW-1:0] ^ 16'h5A3C;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model and monitor: in-order returns after a fixed latency, scoreboard on outputs
    initial forever begin
        @(posedge pixel_clk);
        cyc++;
        #1;
        model_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata = pend_data.pop_front();
            void'(pend_due.pop_front());
        end else if (stray) begin
            mem_rvalid = 1'b1;
            mem_rdata = 16'h0BAD;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata = '0;
        end
        #3;
        if (disp_ack) n_ack++;
        if (mem_cmd_valid && !mem_cmd_we) begin
            check("draw_blocked_during_reads", draw_ready, 0);
            if (stalled) check("stall_addr_stable", mem_cmd_addr, stall_addr);
            if (mem_cmd_ready) begin
                stalled = 0;
                n_rd++;
                if (exp_addr_q.size() == 0) check("rd_cmd_unexpected", 1, 0);
                else check("rd_cmd_addr", mem_cmd_addr, exp_addr_q.pop_front());
                pend_due.push_back(cyc + latency);
                pend_data.push_back(mdata(mem_cmd_addr));
            end else begin
                stalled = 1;
                stall_addr = mem_cmd_addr;
            end
        end else stalled = 0;
        if (mem_cmd_valid && mem_cmd_we && mem_cmd_ready && wr_at_rd < 0) begin
            wr_at_rd = n_rd;
            wr_at_rv = n_rv;
        end
        if (disp_rvalid) begin
            n_rv++;
            if (exp_data_q.size() == 0) check("rvalid_unexpected", 1, 0);
            else check("rdata", disp_rdata, exp_data_q.pop_front());
            check("done_on_last_rvalid", disp_done, n_rv == BL);
        end else if (disp_done) check("done_without_rvalid", 1, 0);
        else if (mem_rvalid && exp_data_q.size() > 0) check("rvalid_missing", 0, 1);
        if (disp_done) n_done++;
    end

    task automatic start_burst(logic [AW-1:0] a, logic dv);
        for (int i = 0; i < BL; i++) begin
            logic [AW-1:0] x;
            x = a + AW'(i);
            exp_addr_q.push_back(x);
            exp_data_q.push_back(mdata(x));
        end
        n_ack = 0;
        n_rd = 0;
        n_rv = 0;
        @(posedge pixel_clk);
        #1;
        disp_req = 1'b1;
        disp_addr = a;
        draw_valid = dv;
        draw_addr = 20'h3C3C3;
        draw_wdata = 16'h7E57;
        #2;
        check("req_cycle_cmd_valid", mem_cmd_valid, 0);
        check("req_cycle_draw_ready", draw_ready, 0);
        @(posedge pixel_clk);
        #1;
        disp_addr = ~a;
        #2;
        check("ack_pulse", disp_ack, 1);
        check("first_rd_valid", mem_cmd_valid & ~mem_cmd_we, 1);
        check("first_rd_addr", mem_cmd_addr, a);
    endtask

    task automatic wait_rd(int n);
        for (int i = 0; i < 400 && n_rd < n; i++) @(negedge pixel_clk);
        check("rd_count_reached", n_rd >= n, 1);
    endtask

    task automatic wait_done();
        int d0;
        d0 = n_done;
        for (int i = 0; i < 400 && n_done == d0; i++) @(negedge pixel_clk);
        check("done_seen", n_done - d0, 1);
        @(posedge pixel_clk);
        #1;
        disp_req = 1'b0;
        check("one_ack", n_ack, 1);
        check("read_cmds", n_rd, BL);
        check("read_returns", n_rv, BL);
        check("exp_addr_drained", exp_addr_q.size(), 0);
    endtask

    task automatic stray_return(string name);
        @(posedge pixel_clk);
        #1;
        stray = 1;
        #2;
        check(name, disp_rvalid, 0);
        @(posedge pixel_clk);
        #1;
        stray = 0;
    endtask

    initial begin
        int late;
        vecs[0] = '{1'b1, 1'b1, 20'h12345, 16'hBEEF, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 20'h00001, 16'h1234, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 20'hFFFFF, 16'hFFFF, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 20'h00000, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 20'hABCDE, 16'h0F0F, 1'b1, 1'b1};
        repeat (2) @(negedge pixel_clk);
        check("rst_disp_ack", disp_ack, 0);
        check("rst_disp_done", disp_done, 0);
        check("rst_disp_rvalid", disp_rvalid, 0);
        check("rst_underrun", underrun, 0);
        check("rst_cmd_valid", mem_cmd_valid, 0);
        check("rst_draw_ready", draw_ready, 1);
        @(posedge pixel_clk);
        #1;
        reset = 1'b0;
        foreach (vecs[i]) begin
            @(posedge pixel_clk);
            #1;
            draw_valid = vecs[i].dv;
            tb_ready = vecs[i].rdy;
            draw_addr = vecs[i].a;
            draw_wdata = vecs[i].d;
            #2;
            check("draw_cmd_valid", mem_cmd_valid, vecs[i].ev);
            check("draw_ready", draw_ready, vecs[i].er);
            check("draw_we", mem_cmd_we, 1);
            check("draw_addr", mem_cmd_addr, vecs[i].a);
            check("draw_wdata", mem_cmd_wdata, vecs[i].d);
        end
        @(posedge pixel_clk);
        #1;
        draw_valid = 1'b0;
        manual = 1'b0;
        line_start = 1'b1;
        @(posedge pixel_clk);
        #1;
        line_start = 1'b0;
        #2;
        check("underrun_idle_line_start", underrun, 0);
        start_burst(20'hFFFF8, 1'b0);
        wait_done();
        wr_at_rd = -1;
        start_burst(20'h00040, 1'b1);
        wait_done();
        draw_valid = 1'b0;
        check("write_after_last_rd_cmd", wr_at_rd, BL);
        check("write_before_last_return", wr_at_rv < BL, 1);
        rand_ready = 1;
        start_burst(20'h00100, 1'b0);
        wait_done();
        rand_ready = 0;
        stray_return("stray_after_burst_dropped");
        latency = 10;
        start_burst(20'h07FF0, 1'b0);
        wait_rd(BL);
        @(posedge pixel_clk);
        #1;
        line_start = 1'b1;
        @(posedge pixel_clk);
        #1;
        line_start = 1'b0;
        #2;
        check("underrun_set", underrun, UEN);
        wait_done();
        repeat (3) @(posedge pixel_clk);
        #3;
        check("underrun_sticky", underrun, UEN);
        latency = 40;
        start_burst(20'h20000, 1'b0);
        wait_rd(5);
        @(posedge pixel_clk);
        #1;
        reset = 1'b1;
        disp_req = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        repeat (2) @(posedge pixel_clk);
        #1;
        reset = 1'b0;
        check("reset_clears_underrun", underrun, 0);
        late = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge pixel_clk);
            #3;
            if (mem_rvalid) begin
                late++;
                check("late_return_dropped", disp_rvalid, 0);
            end
        end
        check("late_returns_seen", late, 5);
        @(posedge pixel_clk);
        #1;
        draw_valid = 1'b1;
        draw_addr = 20'h55555;
        #2;
        check("post_reset_draw_valid", mem_cmd_valid & mem_cmd_we, 1);
        check("post_reset_draw_ready", draw_ready, 1);
        @(posedge pixel_clk);
        #1;
        draw_valid = 1'b0;
        latency = 3;
        start_burst(20'h00ABC, 1'b0);
        wait_done();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
